// File: rtl/hex_word_tx_seq.sv
// hex_word_tx_seq: streams a captured word to a UART TX as uppercase ASCII hex,
// MSB nibble first, optionally followed by CR LF. Owns the TX start/busy handshake.
module hex_word_tx_seq #(
  parameter int unsigned NIBBLES     = 8,
  parameter int unsigned ADD_CRLF    = 1,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [4*NIBBLES-1:0] DATA,
  input  logic                 START,
  output logic                 READY,
  output logic                 DONE,
  output logic                 ERR,
  output logic [7:0]           TX_DATA,
  output logic                 TX_START,
  input  logic                 TX_BUSY
);

  localparam int unsigned DW  = 4 * NIBBLES;
  localparam int unsigned LEN = NIBBLES + ((ADD_CRLF != 0) ? 2 : 0);
  localparam int unsigned IW  = $clog2(LEN + 1);
  localparam int unsigned TW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IW-1:0] NIB_I   = IW'(NIBBLES);
  localparam logic [IW-1:0] LAST_I  = IW'(LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [DW-1:0] word, word_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          done_n, err_n, txs_n;
  logic [7:0]    txd_n;
  logic [3:0]    nib;
  logic [7:0]    ch;

  assign READY = (state == IDLE);

  // Character for the current index: top nibble of the shifted word, then CR, LF.
  always_comb begin
    nib = word[DW-1 -: 4];
    ch  = 8'h0A;
    if (idx < NIB_I) begin
      ch = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    end else if (idx == NIB_I) begin
      ch = 8'h0D;
    end
  end

  // Next-state and next-output logic; TX_START and DONE default low so they pulse.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    word_n  = word;
    tcnt_n  = tcnt;
    done_n  = 1'b0;
    err_n   = ERR;
    txd_n   = TX_DATA;
    txs_n   = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          word_n  = DATA;
          idx_n   = '0;
          err_n   = 1'b0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (!TX_BUSY) begin
          txd_n   = ch;
          txs_n   = 1'b1;
          tcnt_n  = '0;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (TX_BUSY) begin
          state_n = WAIT_DONE;
        end else if (tcnt == TO_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (idx == LAST_I) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            idx_n   = idx + IW'(1);
            word_n  = word << 4;
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously so a reset abandons the frame at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      word     <= '0;
      tcnt     <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      TX_DATA  <= '0;
      TX_START <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      word     <= word_n;
      tcnt     <= tcnt_n;
      DONE     <= done_n;
      ERR      <= err_n;
      TX_DATA  <= txd_n;
      TX_START <= txs_n;
    end
  end

endmodule

// File: tb/tb_hex_word_tx_seq.sv
// Bench for hex_word_tx_seq: a CR LF instance (a) and a digits-only instance (b),
// each fed by a simple UART busy responder and checked against a frame model.
module tb_hex_word_tx_seq;

  typedef logic [7:0] bq_t[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // instance a (ADD_CRLF=1)
  logic [31:0] data_a;
  logic        start_a, ready_a, done_a, err_a, txs_a, busy_a;
  logic [7:0]  txd_a;
  // instance b (ADD_CRLF=0)
  logic [31:0] data_b;
  logic        start_b, ready_b, done_b, err_b, txs_b, busy_b;
  logic [7:0]  txd_b;

  bit  resp_en = 1'b1;
  bit  busy_force = 1'b0;
  int  busy_len = 10;
  int  busy_cnt_a = 0, busy_cnt_b = 0;
  bq_t txq_a, txq_b;
  int  done_cnt_a = 0, done_cnt_b = 0;
  int  width_viol = 0, hs_viol = 0, last_txs_cyc = 0;
  bit  prev_txs = 1'b0, hs_pend = 1'b0, hs_seen = 1'b0;

  assign busy_a = busy_force | (busy_cnt_a != 0);
  assign busy_b = (busy_cnt_b != 0);

  hex_word_tx_seq #(.NIBBLES(8), .ADD_CRLF(1), .ACK_TIMEOUT(16)) dut_a (
    .CLK(clk), .RST(rst), .DATA(data_a), .START(start_a), .READY(ready_a), .DONE(done_a),
    .ERR(err_a), .TX_DATA(txd_a), .TX_START(txs_a), .TX_BUSY(busy_a));

  hex_word_tx_seq #(.NIBBLES(8), .ADD_CRLF(0), .ACK_TIMEOUT(16)) dut_b (
    .CLK(clk), .RST(rst), .DATA(data_b), .START(start_b), .READY(ready_b), .DONE(done_b),
    .ERR(err_b), .TX_DATA(txd_b), .TX_START(txs_b), .TX_BUSY(busy_b));

  // Monitor and busy responder for instance a: logs characters, DONE pulses, handshake breaches.
  always @(negedge clk) begin
    cyc++;
    if (rst || ready_a) begin
      hs_pend = 1'b0;
      hs_seen = 1'b0;
    end
    if (!rst) begin
      if (txs_a) begin
        txq_a.push_back(txd_a);
        last_txs_cyc = cyc;
        if (prev_txs) width_viol++;
        if (hs_pend) hs_viol++;
        hs_pend = 1'b1;
        hs_seen = 1'b0;
      end else if (hs_pend) begin
        if (busy_a) hs_seen = 1'b1;
        else if (hs_seen) hs_pend = 1'b0;
      end
      if (done_a) done_cnt_a++;
    end
    prev_txs = txs_a;
    if (busy_cnt_a > 0) busy_cnt_a--;
    if (txs_a && resp_en && !rst) busy_cnt_a = busy_len;
  end

  // Monitor and fixed 3-cycle busy responder for instance b.
  always @(negedge clk) begin
    if (!rst) begin
      if (txs_b) txq_b.push_back(txd_b);
      if (done_b) done_cnt_b++;
    end
    if (busy_cnt_b > 0) busy_cnt_b--;
    if (txs_b && !rst) busy_cnt_b = 3;
  end

  // Reference frame: hex digits MSB first, uppercase, optional CR LF.
  function automatic bq_t exp_frame(input logic [31:0] w, input bit crlf);
    bq_t q;
    int v;
    for (int i = 7; i >= 0; i--) begin
      v = int'((w >> (4 * i)) & 32'hF);
      q.push_back(8'(v < 10 ? 48 + v : 65 + v - 10));
    end
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction

  function automatic bq_t tail(input bq_t q, input int from);
    bq_t r;
    for (int i = from; i < q.size(); i++) r.push_back(q[i]);
    return r;
  endfunction

  function automatic bit q_eq(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q2s(input bq_t q);
    string s = "";
    for (int i = 0; i < q.size(); i++) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit b, input logic [31:0] w);
    if (b) begin data_b = w; start_b = 1'b1; end
    else   begin data_a = w; start_a = 1'b1; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Waits for the DONE count to reach target, scrambling DATA meanwhile.
  task automatic wait_done(input bit b, input int target, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      data_a = $urandom;
      data_b = $urandom;
      if ((b ? done_cnt_b : done_cnt_a) >= target) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) tick();
    tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_a); end
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_a); end
    tests++; if (txs_a !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b want 0", txs_a); end
    tests++; if (txd_a !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", txd_a); end
    tests++; if (ready_b !== 1'b1) begin fails++; $display("FAIL reset_ready_b: got %b want 1", ready_b); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_spec_word();
    int base = txq_a.size();
    int d0 = done_cnt_a;
    bit to;
    bq_t got, exp;
    busy_len = 10;
    pulse_start(1'b0, 32'h1234ABCD);
    tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL accept_ready: got %b want 0", ready_a); end
    tests++; if (txs_a !== 1'b0) begin fails++; $display("FAIL early_tx_start: got %b want 0", txs_a); end
    tick();
    tests++; if (txs_a !== 1'b1) begin fails++; $display("FAIL first_tx_start: got %b want 1", txs_a); end
    tests++; if (txd_a !== 8'h31) begin fails++; $display("FAIL first_tx_data: got %h want 31", txd_a); end
    wait_done(1'b0, d0 + 1, 400, to);
    tests++; if (to) begin fails++; $display("FAIL spec_done_timeout: got no DONE want DONE"); end
    tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL ready_with_done: got %b want 1", ready_a); end
    repeat (4) tick();
    got = tail(txq_a, base);
    exp = exp_frame(32'h1234ABCD, 1'b1);
    tests++; if (!q_eq(got, exp)) begin fails++; $display("FAIL spec_frame: got [%s] want [%s]", q2s(got), q2s(exp)); end
    tests++; if (done_cnt_a - d0 !== 1) begin fails++; $display("FAIL spec_done_count: got %0d want 1", done_cnt_a - d0); end
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL spec_err: got %b want 0", err_a); end
    tests++; if (width_viol !== 0) begin fails++; $display("FAIL start_width: got %0d wide pulses want 0", width_viol); end
    tests++; if (hs_viol !== 0) begin fails++; $display("FAIL handshake: got %0d early starts want 0", hs_viol); end
  endtask

  task automatic test_no_crlf();
    logic [31:0] words [2];
    words[0] = 32'h00000000;
    words[1] = 32'hFFFFFFFF;
    for (int n = 0; n < 2; n++) begin
      int base = txq_b.size();
      int d0 = done_cnt_b;
      bit to;
      bq_t got, exp;
      pulse_start(1'b1, words[n]);
      wait_done(1'b1, d0 + 1, 300, to);
      tests++; if (to) begin fails++; $display("FAIL nocrlf_timeout %0d: got no DONE want DONE", n); end
      repeat (3) tick();
      got = tail(txq_b, base);
      exp = exp_frame(words[n], 1'b0);
      tests++; if (!q_eq(got, exp)) begin fails++; $display("FAIL nocrlf_frame %0d: got [%s] want [%s]", n, q2s(got), q2s(exp)); end
      tests++; if (done_cnt_b - d0 !== 1) begin fails++; $display("FAIL nocrlf_done %0d: got %0d want 1", n, done_cnt_b - d0); end
    end
  endtask

  task automatic test_busy_hold();
    int base = txq_a.size();
    int d0 = done_cnt_a;
    int h0 = hs_viol;
    logic [31:0] w = $urandom;
    bit to = 1'b1;
    bq_t got, exp;
    busy_force = 1'b1;
    pulse_start(1'b0, w);
    for (int i = 0; i < 20; i++) begin
      tick();
      start_a = (i % 5 == 2);
      data_a = $urandom;
    end
    start_a = 1'b0;
    tests++; if (txq_a.size() - base !== 0) begin fails++; $display("FAIL busy_hold_starts: got %0d want 0", txq_a.size() - base); end
    tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL busy_hold_ready: got %b want 0", ready_a); end
    busy_force = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (done_cnt_a > d0) begin to = 1'b0; break; end
      start_a = (i % 7 == 3);
      data_a = $urandom;
    end
    start_a = 1'b0;
    tests++; if (to) begin fails++; $display("FAIL busy_hold_timeout: got no DONE want DONE"); end
    repeat (4) tick();
    got = tail(txq_a, base);
    exp = exp_frame(w, 1'b1);
    tests++; if (!q_eq(got, exp)) begin fails++; $display("FAIL busy_hold_frame: got [%s] want [%s]", q2s(got), q2s(exp)); end
    tests++; if (done_cnt_a - d0 !== 1) begin fails++; $display("FAIL busy_hold_done: got %0d want 1", done_cnt_a - d0); end
    tests++; if (hs_viol - h0 !== 0) begin fails++; $display("FAIL busy_hold_handshake: got %0d want 0", hs_viol - h0); end
  endtask

  task automatic test_timeout();
    int base = txq_a.size();
    int d0 = done_cnt_a;
    bit to = 1'b1;
    bq_t got, exp;
    resp_en = 1'b0;
    pulse_start(1'b0, $urandom);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (err_a === 1'b1) begin to = 1'b0; break; end
    end
    tests++; if (to) begin fails++; $display("FAIL timeout_err: got ERR=0 want ERR=1"); end
    tests++; if (cyc - last_txs_cyc !== 16) begin fails++; $display("FAIL timeout_delay: got %0d want 16", cyc - last_txs_cyc); end
    tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL timeout_ready: got %b want 1", ready_a); end
    repeat (10) tick();
    tests++; if (txq_a.size() - base !== 1) begin fails++; $display("FAIL timeout_starts: got %0d want 1", txq_a.size() - base); end
    tests++; if (done_cnt_a - d0 !== 0) begin fails++; $display("FAIL timeout_done: got %0d want 0", done_cnt_a - d0); end
    tests++; if (err_a !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", err_a); end
    resp_en = 1'b1;
    base = txq_a.size();
    d0 = done_cnt_a;
    pulse_start(1'b0, 32'h00000001);
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", err_a); end
    wait_done(1'b0, d0 + 1, 400, to);
    tests++; if (to) begin fails++; $display("FAIL after_timeout_done: got no DONE want DONE"); end
    repeat (3) tick();
    got = tail(txq_a, base);
    exp = exp_frame(32'h00000001, 1'b1);
    tests++; if (!q_eq(got, exp)) begin fails++; $display("FAIL after_timeout_frame: got [%s] want [%s]", q2s(got), q2s(exp)); end
  endtask

  task automatic test_reset_mid();
    int base = txq_a.size();
    int d0;
    int n;
    bit to = 1'b1;
    bq_t got, exp;
    pulse_start(1'b0, $urandom);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (txq_a.size() >= base + 3) begin to = 1'b0; break; end
    end
    tests++; if (to) begin fails++; $display("FAIL mid_reach_third: got %0d chars want 3", txq_a.size() - base); end
    repeat (2) tick();
    rst = 1'b1;
    #1;
    tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL mid_rst_ready: got %b want 1", ready_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL mid_rst_done: got %b want 0", done_a); end
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL mid_rst_err: got %b want 0", err_a); end
    tests++; if (txs_a !== 1'b0) begin fails++; $display("FAIL mid_rst_tx_start: got %b want 0", txs_a); end
    tests++; if (txd_a !== 8'h00) begin fails++; $display("FAIL mid_rst_tx_data: got %h want 00", txd_a); end
    tick();
    rst = 1'b0;
    n = txq_a.size();
    repeat (15) tick();
    tests++; if (txq_a.size() !== n) begin fails++; $display("FAIL mid_rst_quiet: got %0d starts want 0", txq_a.size() - n); end
    base = txq_a.size();
    d0 = done_cnt_a;
    pulse_start(1'b0, 32'h0000000F);
    wait_done(1'b0, d0 + 1, 400, to);
    tests++; if (to) begin fails++; $display("FAIL post_rst_done: got no DONE want DONE"); end
    repeat (3) tick();
    got = tail(txq_a, base);
    exp = exp_frame(32'h0000000F, 1'b1);
    tests++; if (!q_eq(got, exp)) begin fails++; $display("FAIL post_rst_frame: got [%s] want [%s]", q2s(got), q2s(exp)); end
  endtask

  task automatic test_back_to_back();
    int base = txq_a.size();
    int d0 = done_cnt_a;
    bit to = 1'b1;
    bit gap_pending = 1'b0;
    bit gap_checked = 1'b0;
    bq_t got, exp;
    data_a = 32'hDEADBEEF;
    start_a = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (gap_pending) begin
        tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL b2b_reaccept: got READY=%b want 0", ready_a); end
        gap_pending = 1'b0;
        gap_checked = 1'b1;
      end
      if (done_a === 1'b1 && !gap_checked) gap_pending = 1'b1;
      if (done_cnt_a >= d0 + 2) begin to = 1'b0; break; end
    end
    start_a = 1'b0;
    tests++; if (to) begin fails++; $display("FAIL b2b_timeout: got %0d DONEs want 2", done_cnt_a - d0); end
    repeat (4) tick();
    got = tail(txq_a, base);
    exp = exp_frame(32'hDEADBEEF, 1'b1);
    exp = {exp, exp};
    tests++; if (!q_eq(got, exp)) begin fails++; $display("FAIL b2b_frames: got [%s] want [%s]", q2s(got), q2s(exp)); end
    tests++; if (done_cnt_a - d0 !== 2) begin fails++; $display("FAIL b2b_done: got %0d want 2", done_cnt_a - d0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [31:0] w = $urandom;
      int base = txq_a.size();
      int d0 = done_cnt_a;
      bit to;
      bq_t got, exp;
      busy_len = $urandom_range(1, 12);
      pulse_start(1'b0, w);
      wait_done(1'b0, d0 + 1, 600, to);
      tests++; if (to) begin fails++; $display("FAIL rand_timeout %0d: got no DONE want DONE", n); end
      tick();
      got = tail(txq_a, base);
      exp = exp_frame(w, 1'b1);
      tests++; if (!q_eq(got, exp)) begin fails++; $display("FAIL rand_frame %0d: got [%s] want [%s]", n, q2s(got), q2s(exp)); end
    end
    busy_len = 10;
    tests++; if (width_viol !== 0) begin fails++; $display("FAIL final_start_width: got %0d want 0", width_viol); end
    tests++; if (hs_viol !== 0) begin fails++; $display("FAIL final_handshake: got %0d want 0", hs_viol); end
  endtask

  initial begin
    test_reset();
    test_spec_word();
    test_no_crlf();
    test_busy_hold();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
